seq_adder_ctrl_64: RTL and testbench

SEQ_ADDER_CTRL_64 -- requirements
Module: seq_adder_ctrl_64

---
 rtl/seq_adder_ctrl_64.sv | 110 +++++++++++
 tb/tb_seq_adder_ctrl_64.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_ctrl_64.sv
// 64-bit adder that reuses a single SLICE_W-bit adder slice over N_SLICE cycles,
// LSB slice first, with a start/busy/done handshake.
module seq_adder_ctrl_64 #(
    parameter int unsigned SLICE_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] x,
    input  logic [63:0] y,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic [63:0] sum,
    output logic        carry_out,
    output logic        overflow
);

    localparam int unsigned N_SLICE = 64 / SLICE_W;
    localparam int unsigned IDX_W   = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [63:0]        r_a;
    logic [63:0]        r_b;
    logic               r_carry;
    logic [63:0]        r_sum;
    logic               r_carry_out;
    logic               r_overflow;

    logic               w_accept;
    logic               w_last;
    logic [5:0]         w_base;
    logic [SLICE_W-1:0] w_a_slice;
    logic [SLICE_W-1:0] w_b_slice;
    logic [SLICE_W-1:0] w_slice_sum;
    logic               w_slice_carry;

    assign w_accept  = start && (r_state != S_RUN);
    assign w_last    = (r_idx == IDX_W'(N_SLICE - 1));
    assign w_base    = 6'(r_idx) * 6'(SLICE_W);
    assign w_a_slice = r_a[w_base +: SLICE_W];
    assign w_b_slice = r_b[w_base +: SLICE_W];

    // The only adder in the datapath: one slice plus the running carry.
    assign {w_slice_carry, w_slice_sum} = {1'b0, w_a_slice} + {1'b0, w_b_slice}
                                        + {{SLICE_W{1'b0}}, r_carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_idx       <= '0;
            r_a         <= x;
            r_b         <= y;
            r_carry     <= carry_in;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_sum[w_base +: SLICE_W] <= w_slice_sum;
            r_carry                  <= w_slice_carry;
            if (w_last) begin
                // Index parks on the last slice; the next accepted start reloads it.
                r_carry_out <= w_slice_carry;
                r_overflow  <= (r_a[63] == r_b[63]) && (w_slice_sum[SLICE_W-1] != r_a[63]);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_seq_adder_ctrl_64.sv
// Scoreboard bench: three instances (SLICE_W 16, 8, 32) share stimulus; an
// arithmetic reference predicts acceptance, latency and results per instance.
module tb_seq_adder_ctrl_64;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] x     = '0;
    logic [63:0] y     = '0;
    logic        cin   = 1'b0;

    logic        busy_w [3];
    logic        done_w [3];
    logic [63:0] sum_w  [3];
    logic        co_w   [3];
    logic        ov_w   [3];

    always #5 clk = ~clk;

    seq_adder_ctrl_64 #(.SLICE_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .carry_in(cin),
        .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]),
        .carry_out(co_w[0]), .overflow(ov_w[0])
    );
    seq_adder_ctrl_64 #(.SLICE_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .carry_in(cin),
        .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]),
        .carry_out(co_w[1]), .overflow(ov_w[1])
    );
    seq_adder_ctrl_64 #(.SLICE_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .carry_in(cin),
        .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]),
        .carry_out(co_w[2]), .overflow(ov_w[2])
    );

    typedef struct packed {
        logic [63:0] sum;
        logic        co;
        logic        ov;
        int          cyc;
    } exp_t;

    int unsigned NS [3] = '{4, 8, 2};
    int unsigned WS [3] = '{16, 8, 32};

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          acc_valid [3];
    int          acc_cyc   [3];
    logic [63:0] cur_sum   [3];
    logic [63:0] held_sum  [3];
    logic        held_co   [3];
    logic        held_ov   [3];

    function automatic void chk(string name, int d, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d (W=%0d) t=%0t got=%h exp=%h", name, d, WS[d], $time, act, exp);
        end
    endfunction

    function automatic int q_size(int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t q_front(int d);
        case (d)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic exp_t q_pop(int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void q_push(int d, exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    // Reference: a request is taken unless an addition accepted at edge a is still
    // running (edges a+1..a+N); the result appears N edges after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                acc_valid[d] = 1'b0;
                held_sum[d]  = '0;
                held_co[d]   = 1'b0;
                held_ov[d]   = 1'b0;
            end
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            cyc = cyc + 1;
            for (int d = 0; d < 3; d++) begin
                if (start && !(acc_valid[d] && cyc <= acc_cyc[d] + int'(NS[d]))) begin
                    logic [64:0] full;
                    exp_t        e;
                    full  = {1'b0, x} + {1'b0, y} + {64'd0, cin};
                    e.sum = full[63:0];
                    e.co  = full[64];
                    e.ov  = (x[63] == y[63]) && (full[63] != x[63]);
                    e.cyc = cyc + int'(NS[d]);
                    q_push(d, e);
                    acc_valid[d] = 1'b1;
                    acc_cyc[d]   = cyc;
                    cur_sum[d]   = e.sum;
                    held_sum[d]  = e.sum;
                    held_co[d]   = e.co;
                    held_ov[d]   = e.ov;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                chk("reset_busy", d, busy_w[d], 0);
                chk("reset_done", d, done_w[d], 0);
                chk("reset_sum",  d, sum_w[d],  0);
                chk("reset_co",   d, co_w[d],   0);
                chk("reset_ov",   d, ov_w[d],   0);
            end else begin
                bit   running;
                bit   due;
                exp_t e;
                running = acc_valid[d] && (cyc < acc_cyc[d] + int'(NS[d]));
                due     = (q_size(d) > 0) && (q_front(d).cyc <= cyc);
                chk("busy", d, busy_w[d], running);
                chk("done", d, done_w[d], due);
                if (done_w[d] && q_size(d) > 0) begin
                    e = q_pop(d);
                    chk("latency",   d, cyc,      e.cyc);
                    chk("sum",       d, sum_w[d], e.sum);
                    chk("carry_out", d, co_w[d],  e.co);
                    chk("overflow",  d, ov_w[d],  e.ov);
                end else if (due) begin
                    void'(q_pop(d));
                end
                if (running) begin
                    int unsigned k;
                    logic [63:0] mask;
                    k    = cyc - acc_cyc[d];
                    mask = (64'd1 << (k * WS[d])) - 64'd1;
                    chk("partial_sum", d, sum_w[d], cur_sum[d] & mask);
                    chk("run_co",      d, co_w[d],  0);
                    chk("run_ov",      d, ov_w[d],  0);
                end else if (!done_w[d]) begin
                    chk("held_sum", d, sum_w[d], held_sum[d]);
                    chk("held_co",  d, co_w[d],  held_co[d]);
                    chk("held_ov",  d, ov_w[d],  held_ov[d]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic op(input logic [63:0] a, input logic [63:0] b, input logic c);
        x     = a;
        y     = b;
        cin   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        op(64'd420000021, 64'd500009800, 1'b0);
        op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        op(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);

        // Second request (new operands, start still high) lands while all are running.
        x = 64'd12500002; y = 64'd31030099; cin = 1'b1; start = 1'b1;
        tick();
        x = {$urandom, $urandom}; y = {$urandom, $urandom}; cin = 1'b0;
        tick();
        start = 1'b0;
        repeat (10) tick();

        // Reset two cycles into an addition.
        x = 64'h0123_4567_89AB_CDEF; y = 64'h1111_2222_3333_4444; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("abort_busy", d, busy_w[d], 0);
            chk("abort_done", d, done_w[d], 0);
            chk("abort_sum",  d, sum_w[d],  0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        op(64'd12500002, 64'd31030099, 1'b1);

        // Start held high: back-to-back additions with changing operands.
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            x   = {$urandom, $urandom};
            y   = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        repeat (10) tick();

        for (int i = 0; i < 300; i++) begin
            start = ($urandom_range(0, 3) == 0);
            x     = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            y     = ($urandom_range(0, 7) == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            cin   = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        repeat (12) tick();

        for (int d = 0; d < 3; d++) begin
            chk("drain_pending", d, q_size(d), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
